// File: rtl/f_fetch_pkg.sv
// Shared constants for the fetch stage: default address map and FSM encodings.
// The optional address-error check is enabled by defining FETCH_EXC_EN.
package f_fetch_pkg;

  localparam logic [31:0] ResetPcDefault = 32'h0000_3000;
  localparam logic [31:0] PcMinDefault   = 32'h0000_3000;
  localparam logic [31:0] PcMaxDefault   = 32'h0000_6FFC;

  // IDLE: nothing outstanding; BUSY: outstanding, data kept; DROP: outstanding, data discarded.
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDrop = 2'd2;

  function automatic logic [31:0] pc_step(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/f_addr_chk.sv
// Combinational fetch-address checker: flags misaligned or out-of-window PCs.
// Instantiated by f_fetch only when FETCH_EXC_EN is defined.
module f_addr_chk
  import f_fetch_pkg::*;
#(
  parameter logic [31:0] PC_MIN = PcMinDefault,
  parameter logic [31:0] PC_MAX = PcMaxDefault
) (
  input  logic [31:0] pc,
  output logic        bad
);

  assign bad = (pc[1:0] != 2'b00) || (pc < PC_MIN) || (pc > PC_MAX);

endmodule

// File: rtl/f_fetch.sv
// Fetch stage: PC, req/ack instruction-memory port and a one-entry buffer feeding D.
// Define FETCH_EXC_EN to turn illegal fetch addresses into buffered address-error entries.
module f_fetch
  import f_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPcDefault,
  parameter logic [31:0] PC_MIN   = PcMinDefault,
  parameter logic [31:0] PC_MAX   = PcMaxDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] PC_out,
  output logic        f_valid,
  output logic        exc_adel
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        buf_exc_q, buf_exc_d;

  logic room, redir, issue_idle, addr_bad, ack, exc_load, land, kill;

`ifdef FETCH_EXC_EN
  f_addr_chk #(
    .PC_MIN(PC_MIN),
    .PC_MAX(PC_MAX)
  ) u_addr_chk (
    .pc (pc_q),
    .bad(addr_bad)
  );
  assign exc_adel = buf_valid_q & buf_exc_q;
`else
  logic unused_cfg;
  assign addr_bad   = 1'b0;
  assign exc_adel   = 1'b0;
  assign unused_cfg = ^{PC_MIN, PC_MAX, buf_exc_q};
`endif

  assign room       = !buf_valid_q || !stall;
  assign redir      = redirect && !stall;
  assign issue_idle = (state_q == StIdle) && room;
  assign im_req     = reset && ((issue_idle && !addr_bad) || (state_q == StBusy) ||
                                (state_q == StDrop));
  assign im_addr    = pc_q;
  assign ack        = im_ack && im_req;
  assign exc_load   = issue_idle && addr_bad;
  // A word lands on an ack outside DROP, or immediately when the issue check rejects the PC.
  assign land       = (ack && (state_q != StDrop)) || exc_load;
  // The buffer already holds the delay slot, so whatever is in flight must die.
  assign kill       = redir && buf_valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    buf_valid_d  = buf_valid_q;
    buf_instr_d  = buf_instr_q;
    buf_pc_d     = buf_pc_q;
    buf_exc_d    = buf_exc_q;

    if (buf_valid_q && !stall) begin
      buf_valid_d = 1'b0;
    end

    if (land) begin
      if (!kill) begin
        buf_valid_d = 1'b1;
        buf_instr_d = exc_load ? 32'h0 : im_rdata;
        buf_pc_d    = pc_q;
        buf_exc_d   = exc_load;
      end
      if (redir) begin
        pc_d = redirect_pc;
      end else if (pend_valid_q) begin
        pc_d = pend_pc_q;
      end else begin
        pc_d = pc_step(pc_q);
      end
      pend_valid_d = 1'b0;
      state_d      = StIdle;
    end else if (im_req && (state_q != StDrop)) begin
      state_d = kill ? StDrop : StBusy;
      if (redir) begin
        pend_pc_d    = redirect_pc;
        pend_valid_d = !kill;
      end
    end else if ((state_q == StDrop) && ack) begin
      pc_d         = pend_pc_q;
      pend_valid_d = 1'b0;
      state_d      = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'h0;
      buf_valid_q  <= 1'b0;
      buf_instr_q  <= 32'h0;
      buf_pc_q     <= 32'h0;
      buf_exc_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      buf_valid_q  <= buf_valid_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc_q     <= buf_pc_d;
      buf_exc_q    <= buf_exc_d;
    end
  end

  assign f_valid   = buf_valid_q;
  assign instr_out = buf_valid_q ? buf_instr_q : 32'h0;
  assign PC_out    = buf_valid_q ? buf_pc_q : 32'h0;

endmodule
